// File: rtl/input_row_streamer_if.sv
// input_row_streamer_if: valid/ready row stream carrying 256-bit rows into the matmul array.
// Signals: out_valid/out_data/out_last driven by the streamer (master), out_ready driven by the consumer (slave).
interface input_row_streamer_if #(
    parameter int DATA_W = 256
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    modport master (output out_valid, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/input_row_streamer.sv
// input_row_streamer: reads a programmable number of rows from the packed input buffer and streams them out.
// Ports: clk, rst_n (async active-low); start/cfg_rows launch a pass; mem_en/mem_addr/mem_dout drive the
// 1-cycle-latency memory read port; stream (master modport) carries out_valid/out_ready/out_data/out_last;
// busy spans the pass, done pulses once after the last row handshake.
// Build option: define INPUT_ROW_WORD_REVERSE_EN to reverse the eight 32-bit words of each row.
module input_row_streamer #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_W:0]             cfg_rows,
    output logic                        mem_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_dout,
    input_row_streamer_if.master        stream,
    output logic                        busy,
    output logic                        done
);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] ROWS_MAX = ONE << ADDR_W;
    localparam logic [2:0]      DEPTH    = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W:0]   rows, rows_n, issued, popped;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] push_data;
    logic              wptr, rptr, rd_pend, push, pop;
    logic [1:0]        count;
    logic [2:0]        used;

    // A read issued last cycle lands on mem_dout now and is pushed this cycle.
    assign push   = rd_pend;
    assign pop    = stream.out_valid && stream.out_ready;
    assign rows_n = (cfg_rows == '0 || cfg_rows > ROWS_MAX) ? ROWS_MAX : cfg_rows;

    // Entries held plus reads in flight must leave room for the new read; a pop this cycle frees one slot.
    assign used     = {1'b0, count} + {2'b0, rd_pend};
    assign mem_en   = (state == FETCH) && (issued < rows) && (used < DEPTH + {2'b0, pop});
    assign mem_addr = issued[ADDR_W-1:0];

    assign stream.out_valid = (count != 2'd0);
    assign stream.out_data  = fifo_q[rptr];
    assign stream.out_last  = stream.out_valid && (popped == rows - ONE);

`ifdef INPUT_ROW_WORD_REVERSE_EN
    always_comb begin
        push_data = '0;
        for (int i = 0; i < DATA_W/32; i++)
            push_data[32*i +: 32] = mem_dout[DATA_W-32-32*i +: 32];
    end
`else
    assign push_data = mem_dout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rows      <= '0;
            issued    <= '0;
            popped    <= '0;
            rd_pend   <= 1'b0;
            count     <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_pend <= mem_en;
            count   <= count + {1'b0, push} - {1'b0, pop};
            if (mem_en)
                issued <= issued + ONE;
            if (push) begin
                fifo_q[wptr] <= push_data;
                wptr         <= ~wptr;
            end
            if (pop) begin
                rptr   <= ~rptr;
                popped <= popped + ONE;
            end
            case (state)
                IDLE: if (start) begin
                    rows   <= rows_n;
                    issued <= '0;
                    popped <= '0;
                    busy   <= 1'b1;
                    state  <= FETCH;
                end
                FETCH: if (mem_en && issued + ONE == rows)
                    state <= DRAIN;
                DRAIN: if (pop && stream.out_last) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    push_never_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && {1'b0, count} == DEPTH));
endmodule

// File: doc/input_row_streamer.md
Name: input_row_streamer

Overview:
- Downstream neighbour of the packed input buffer memory (32-bit AXI write side, 256-bit read side).
- Drives that memory's 256-bit read port (en_b/addr_b/dout_b) and streams rows into the matmul array over a valid/ready interface.
- A start pulse launches one pass over a programmable number of rows. An internal 2-entry skid FIFO absorbs the 1-cycle BRAM read latency under backpressure.

Parameters:
- DATA_W, 256, row width in bits (8 x 32-bit words, each holding 2 packed 16-bit elements)
- ADDR_W, 6, row address width; depth = 2**ADDR_W = 64 rows
- FIFO_DEPTH, 2, skid entries; fixed at 2, other values unsupported

Ports:
- clk  in  1  single clock; memory read port shares it
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored unless idle
- cfg_rows  in  ADDR_W+1  rows to stream, sampled on accepted start; 0 means 2**ADDR_W; values > 2**ADDR_W clamp to 2**ADDR_W
- mem_en  out  1  read enable to memory port B
- mem_addr  out  ADDR_W  row address to memory port B
- mem_dout  in  DATA_W  memory port B data, valid one cycle after mem_en
- out_valid  out  1  row data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  DATA_W  row data
- out_last  out  1  high with the final row of the pass
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last row handshake

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0, state IDLE, FIFO empty, counters 0.
- States:
  - IDLE: accepts start, latches row count N, sets busy and goes to FETCH.
  - FETCH: issues reads until N issued, then goes to DRAIN.
  - DRAIN: waits until all N rows are handshaken, then pulses done and returns to IDLE.
- Read issue rule: mem_en=1 in a cycle only if (FIFO occupancy + reads in flight - pops this cycle) < 2 and issued < N. mem_addr = issued count, starting at 0 and incrementing by 1 per issued read.
- A read issued in cycle t pushes mem_dout into the FIFO in cycle t+1.
- The flow-control rule guarantees the FIFO is never full at push time; push on a full FIFO is a design error and must be covered by an assertion.
- Latency: start at cycle 0 -> mem_en at cycle 1 -> out_valid at cycle 3 (pushed at 2, registered output).
- Sustained throughput is 1 row/cycle while out_ready=1.
- out_valid/out_data/out_last are driven from the FIFO head.
- Once out_valid=1, out_data and out_last hold stable until the handshake.
- out_last=1 exactly on row index N-1.
- Simultaneous push and pop on a 1-entry FIFO keeps occupancy at 1; on an empty FIFO, push only.
- done is asserted one cycle after the handshake of the out_last row. busy drops in the same cycle as done.
- start while busy is ignored, with no effect on the current pass.
- out_ready low for any length stalls issue; no row is lost or duplicated.
- N = 2**ADDR_W: addresses 0..63. The address counter does not wrap within a pass; ADDR_W+1 bits internally.
- Reset mid-pass aborts immediately: FIFO is flushed and outputs go to reset values. The next start begins at row 0.

Optional Feature:
- Macro: INPUT_ROW_WORD_REVERSE_EN.
- Defined: out_data is mem_dout with its eight 32-bit words reversed, so memory word 8*row+0 appears at out_data[31:0] and word 8*row+7 at out_data[255:224].
- Undefined: out_data equals mem_dout unchanged, with word 8*row+0 at out_data[255:224].
- Latency and handshake are identical in both builds.

Test Plan:
- Full pass, no backpressure:
  - Stimulus: memory row r filled with words {r,0..7} pattern; cfg_rows=0, out_ready=1, pulse start.
  - Required: 64 rows in order on consecutive cycles 3..66; out_last at row 63; done at cycle 67; busy low after.
- Short pass:
  - Stimulus: cfg_rows=3.
  - Required: mem_addr 0,1,2 only; out_last on row 2; exactly 3 handshakes, then done.
- Backpressure:
  - Stimulus: cfg_rows=8, out_ready toggling 1,0,0,1,0,...
  - Required: all 8 rows are delivered exactly once, in order.
  - Required: out_data is stable while stalled.
  - Required: FIFO never overflows; mem_en is never high with 2 occupied plus 0 pops.
- Restart rejection:
  - Stimulus: pulse start again during row 5 of a 10-row pass.
  - Required: the pass completes with 10 rows and a single done; no second pass begins.
- Reset mid-pass:
  - Stimulus: assert rst_n=0 asynchronously at row 4 of 64.
  - Required: outputs are 0 immediately.
  - Required: a new start with cfg_rows=2 yields rows 0,1 and done.
- Word order (both builds):
  - Stimulus: row 0 words 0x00000000..0x00000007.
  - Required, macro undefined: out_data[255:224]=0x0.
  - Required, macro defined: out_data[31:0]=0x0 and out_data[255:224]=0x7.
